// File: rtl/axil_pkg.sv
// Shared AXI-Lite RAM slave types: response codes, FSM state encodings, arbiter grants.
package axil_pkg;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   typedef enum logic [4:0] {
      W_IDLE   = 5'b00001,
      W_ADDR   = 5'b00010,
      W_DATA   = 5'b00100,
      W_COMMIT = 5'b01000,
      W_RESP   = 5'b10000
   } wstate_e;

   typedef enum logic [2:0] {
      R_IDLE = 3'b001,
      R_REQ  = 3'b010,
      R_RESP = 3'b100
   } rstate_e;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'b00,
      GNT_READ  = 2'b01,
      GNT_WRITE = 2'b10
   } grant_e;

endpackage

// File: rtl/axil_ram_sp.sv
// Single-port word array with per-byte write enables and a registered read port.
module axil_ram_sp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned IDX_W      = 10
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_re,
   input  logic                  i_re_zero,
   input  logic [STRB_WIDTH-1:0] i_we,
   input  logic [IDX_W-1:0]      i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
         if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
   end

   // Read register doubles as the bus rdata holding register; out-of-range reads load zero.
   always_ff @(posedge clk) begin
      if (i_rst)     r_q <= '0;
      else if (i_re) r_q <= i_re_zero ? '0 : r_mem[i_addr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI-Lite slave backing a byte-writable RAM; read and write FSMs share the array via a fair arbiter.
module axil_ram_slave
   import axil_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned           MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned WIDX_W = ADDR_WIDTH - 2;

   wstate_e               r_wstate;
   rstate_e               r_rstate;
   grant_e                r_last;
   grant_e                w_gnt;

   logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
   logic [1:0]            r_bresp, r_rresp;
   logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;

   logic [ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
   logic                  w_wr_in_range, w_rd_in_range;
   logic [IDX_W-1:0]      w_wr_idx, w_rd_idx, w_ram_addr;
   logic [STRB_WIDTH-1:0] w_ram_we;
   logic                  w_ram_re;
   logic                  w_aw_hs, w_w_hs, w_ar_hs;
   logic                  w_wr_req, w_rd_req;
   logic                  w_unused;

   // Address decode; the two byte-offset bits never fault.
   assign w_wr_off      = r_awaddr - BASE_ADDR;
   assign w_rd_off      = r_araddr - BASE_ADDR;
   assign w_wr_in_range = (r_awaddr >= BASE_ADDR) && (w_wr_off[ADDR_WIDTH-1:2] < WIDX_W'(MEM_DEPTH));
   assign w_rd_in_range = (r_araddr >= BASE_ADDR) && (w_rd_off[ADDR_WIDTH-1:2] < WIDX_W'(MEM_DEPTH));
   assign w_wr_idx      = w_wr_off[IDX_W+1:2];
   assign w_rd_idx      = w_rd_off[IDX_W+1:2];
   assign w_unused      = ^{s_axil_awprot, s_axil_arprot, w_wr_off[1:0], w_rd_off[1:0]};

   assign w_aw_hs  = s_axil_awvalid & r_awready;
   assign w_w_hs   = s_axil_wvalid  & r_wready;
   assign w_ar_hs  = s_axil_arvalid & r_arready;
   assign w_wr_req = (r_wstate == W_COMMIT);
   assign w_rd_req = (r_rstate == R_REQ);

   // Lone requester wins immediately; on contention the side not granted last wins.
   always_comb begin
      w_gnt = GNT_NONE;
      if (w_rd_req && w_wr_req) w_gnt = (r_last == GNT_READ) ? GNT_WRITE : GNT_READ;
      else if (w_rd_req)        w_gnt = GNT_READ;
      else if (w_wr_req)        w_gnt = GNT_WRITE;
   end

   always_ff @(posedge clk) begin
      if (reset)                  r_last <= GNT_WRITE;
      else if (w_gnt != GNT_NONE) r_last <= w_gnt;
   end

   assign w_ram_we   = (w_gnt == GNT_WRITE && w_wr_in_range && !reset) ? r_wstrb : '0;
   assign w_ram_re   = (w_gnt == GNT_READ) && !reset;
   assign w_ram_addr = (w_gnt == GNT_WRITE) ? w_wr_idx : w_rd_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXIL_RESP_OKAY;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) r_awaddr <= s_axil_awaddr;
               if (w_w_hs) begin
                  r_wdata <= s_axil_wdata;
                  r_wstrb <= s_axil_wstrb;
               end
               if (w_aw_hs && w_w_hs) begin
                  r_wstate  <= W_COMMIT;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
               end else if (w_aw_hs) begin
                  r_wstate  <= W_ADDR;
                  r_awready <= 1'b0;
               end else if (w_w_hs) begin
                  r_wstate <= W_DATA;
                  r_wready <= 1'b0;
               end
            end
            W_ADDR: begin
               if (w_w_hs) begin
                  r_wdata  <= s_axil_wdata;
                  r_wstrb  <= s_axil_wstrb;
                  r_wstate <= W_COMMIT;
                  r_wready <= 1'b0;
               end
            end
            W_DATA: begin
               if (w_aw_hs) begin
                  r_awaddr  <= s_axil_awaddr;
                  r_wstate  <= W_COMMIT;
                  r_awready <= 1'b0;
               end
            end
            W_COMMIT: begin
               if (w_gnt == GNT_WRITE) begin
                  r_wstate <= W_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wr_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (s_axil_bready) begin
                  r_wstate  <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            default: begin
               r_wstate  <= W_IDLE;
               r_awready <= 1'b1;
               r_wready  <= 1'b1;
               r_bvalid  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rresp   <= AXIL_RESP_OKAY;
         r_araddr  <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_araddr  <= s_axil_araddr;
                  r_rstate  <= R_REQ;
                  r_arready <= 1'b0;
               end
            end
            R_REQ: begin
               if (w_gnt == GNT_READ) begin
                  r_rstate <= R_RESP;
                  r_rvalid <= 1'b1;
                  r_rresp  <= w_rd_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
               end
            end
            R_RESP: begin
               if (s_axil_rready) begin
                  r_rstate  <= R_IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
               end
            end
            default: begin
               r_rstate  <= R_IDLE;
               r_arready <= 1'b1;
               r_rvalid  <= 1'b0;
            end
         endcase
      end
   end

   axil_ram_sp #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk       (clk),
      .i_rst     (reset),
      .i_re      (w_ram_re),
      .i_re_zero (!w_rd_in_range),
      .i_we      (w_ram_we),
      .i_addr    (w_ram_addr),
      .i_wdata   (r_wdata),
      .o_rdata   (s_axil_rdata)
   );

   assign s_axil_awready = r_awready;
   assign s_axil_wready  = r_wready;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign s_axil_arready = r_arready;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Scoreboard bench for axil_ram_slave: model RAM, expected-response queues, latency and arbitration checks.
module tb_axil_ram_slave;

   localparam int unsigned DEPTH = 1024;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] model_mem [int];
   rd_exp_t     rd_exp_q [$];
   logic [1:0]  wr_exp_q [$];

   axil_ram_slave dut (
      .clk(clk), .reset(reset),
      .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] addr);
      return (addr >> 2) < DEPTH;
   endfunction

   // Model write: updates the reference RAM and queues the expected bresp.
   task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int          idx;
      logic [31:0] word;
      idx = int'(addr >> 2);
      if (in_rng(addr)) begin
         word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
         for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
         model_mem[idx] = word;
         wr_exp_q.push_back(2'b00);
      end else begin
         wr_exp_q.push_back(2'b10);
      end
   endtask

   task automatic exp_read(input logic [31:0] addr);
      rd_exp_t e;
      int      idx;
      idx = int'(addr >> 2);
      if (in_rng(addr)) begin
         e.data = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
         e.resp = 2'b00;
      end else begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end
      rd_exp_q.push_back(e);
   endtask

   // Drive any combination of AR/AW/W in the same cycle; returns at the negedge after the handshake.
   task automatic drive(input bit do_ar, input bit do_aw, input bit do_w,
                        input logic [31:0] ar_a, input logic [31:0] aw_a,
                        input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      arvalid = do_ar; araddr = ar_a;
      awvalid = do_aw; awaddr = aw_a;
      wvalid  = do_w;  wdata  = d; wstrb = s;
      while (((do_ar && !arready) || (do_aw && !awready) || (do_w && !wready)) && n < 20) begin
         @(negedge clk); n++;
      end
      if (n >= 20) check("drive_ready_timeout", 32'(n), 32'(0));
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic wait_b(input int hold, output int lat);
      int         n = 0;
      logic [1:0] e;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      lat = n + 1;
      check("b_seen", 32'(bvalid), 32'(1));
      if (wr_exp_q.size() == 0) begin check("b_sb_empty", 32'(0), 32'(1)); return; end
      e = wr_exp_q.pop_front();
      check("bresp", 32'(bresp), 32'(e));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("b_hold_valid", 32'(bvalid), 32'(1));
         check("b_hold_resp", 32'(bresp), 32'(e));
      end
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("b_drop", 32'(bvalid), 32'(0));
   endtask

   task automatic wait_r(output int lat);
      int      n = 0;
      rd_exp_t e;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      lat = n + 1;
      check("r_seen", 32'(rvalid), 32'(1));
      if (rd_exp_q.size() == 0) begin check("r_sb_empty", 32'(0), 32'(1)); return; end
      e = rd_exp_q.pop_front();
      check("rdata", rdata, e.data);
      check("rresp", 32'(rresp), 32'(e.resp));
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      check("r_drop", 32'(rvalid), 32'(0));
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int lat;
      exp_write(a, d, s);
      drive(1'b0, 1'b1, 1'b1, '0, a, d, s);
      wait_b(0, lat);
      check("w_latency", 32'(lat), 32'(2));
   endtask

   task automatic read_word(input logic [31:0] a);
      int lat;
      exp_read(a);
      drive(1'b1, 1'b0, 1'b0, a, '0, '0, '0);
      wait_r(lat);
      check("r_latency", 32'(lat), 32'(2));
   endtask

   initial begin
      int lat_r, lat_b, n;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_awready", 32'(awready), 32'(1));
      check("rst_wready", 32'(wready), 32'(1));
      check("rst_arready", 32'(arready), 32'(1));
      check("rst_bvalid", 32'(bvalid), 32'(0));
      check("rst_rvalid", 32'(rvalid), 32'(0));
      check("rst_rdata", rdata, 32'h0);
      check("rst_resps", 32'({bresp, rresp}), 32'(0));

      write_word(32'h10, 32'hDEADBEEF, 4'hF);
      read_word(32'h10);

      write_word(32'h20, 32'h11223344, 4'hF);
      write_word(32'h20, 32'hAABBCCDD, 4'b0101);
      read_word(32'h20);

      // W leads AW by three cycles; bready withheld for five cycles.
      exp_write(32'h24, 32'h5A5A0001, 4'hF);
      drive(1'b0, 1'b0, 1'b1, '0, '0, 32'h5A5A0001, 4'hF);
      check("w_first_wready", 32'(wready), 32'(0));
      check("w_first_awready", 32'(awready), 32'(1));
      repeat (2) @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, '0, 32'h24, '0, '0);
      wait_b(5, lat_b);
      check("w_first_latency", 32'(lat_b), 32'(2));
      read_word(32'h24);

      // Out of range: index 1024 must not alias onto word 0.
      write_word(32'h0, 32'hCAFEF00D, 4'hF);
      write_word(32'h1000, 32'h12345678, 4'hF);
      read_word(32'h0);
      read_word(32'h1000);

      // Contention straight after reset: read wins first.
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      exp_read(32'h10);
      exp_write(32'h30, 32'h0BADF00D, 4'hF);
      drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h30, 32'h0BADF00D, 4'hF);
      fork
         wait_r(lat_r);
         wait_b(0, lat_b);
      join
      check("cont1_read_lat", 32'(lat_r), 32'(2));
      check("cont1_write_lat", 32'(lat_b), 32'(3));

      // A lone read leaves read as last grant, so the next contention favours write.
      read_word(32'h30);
      exp_write(32'h34, 32'h600DCAFE, 4'hF);
      exp_read(32'h30);
      drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h34, 32'h600DCAFE, 4'hF);
      fork
         wait_r(lat_r);
         wait_b(0, lat_b);
      join
      check("cont2_write_lat", 32'(lat_b), 32'(2));
      check("cont2_read_lat", 32'(lat_r), 32'(3));
      read_word(32'h34);

      // Reset while a read response is pending drops it.
      exp_read(32'h10);
      drive(1'b1, 1'b0, 1'b0, 32'h10, '0, '0, '0);
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      check("rst_mid_rvalid_seen", 32'(rvalid), 32'(1));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_rvalid", 32'(rvalid), 32'(0));
      check("rst_mid_arready", 32'(arready), 32'(1));
      rd_exp_q.delete();
      reset = 1'b0;
      read_word(32'h10);

      check("sb_rd_empty", 32'(rd_exp_q.size()), 32'(0));
      check("sb_wr_empty", 32'(wr_exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
